// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative multiply/divide unit for the execute stage. It owns the
// architectural HI/LO registers. MULT/MULTU run a radix-2 shift-add, and
// DIV/DIVU run a restoring divide. Both work on operand magnitudes and apply
// the sign in a single FIXUP cycle at the end. MTHI/MTLO write HI/LO
// directly while the unit is idle.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start, op    request in EX: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU,
//                4 MTHI, 5 MTLO, 6/7 no-op
//   a, b         rs / rt operands (forwarded values)
//   rd_req       MFHI/MFLO in EX; it must wait while the unit is busy
//   flush        kills the in-flight operation and blocks start
//   hi, lo       HI / LO registers
//   busy         unit is not idle
//   done         one-cycle pulse after HI/LO are written by mult/div
//   stall        freeze EX and earlier stages
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(ITER);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             sq;        // quotient / product is negative
    logic             sr;        // remainder is negative (dividend sign)
    logic [WIDTH:0]   acc;       // mult: upper product half; div: 33-bit remainder
    logic [WIDTH-1:0] mplr;      // mult: multiplier / lower half; div: dividend -> quotient
    logic [WIDTH-1:0] mcand;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] a_orig;    // raw rs, returned as HI on divide-by-zero

    // ---------------------------------------------------------------------
    // Request decode and operand conditioning
    // ---------------------------------------------------------------------
    logic             accept;
    logic             op_signed;
    logic             op_is_div;
    logic [WIDTH-1:0] a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign accept    = start && !flush && (state == S_IDLE);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_is_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign a_neg     = '0 - a;
    assign b_neg     = '0 - b;
    assign a_mag     = (op_signed && a[WIDTH-1]) ? a_neg : a;
    assign b_mag     = (op_signed && b[WIDTH-1]) ? b_neg : b;

    // ---------------------------------------------------------------------
    // Iteration datapath
    // ---------------------------------------------------------------------
    // Multiply: add the multiplicand into the upper half when the multiplier
    // LSB is set, then shift {carry, acc, mplr} right by one. The carry lands
    // in acc[WIDTH-1], so acc[WIDTH] stays zero on the multiply path.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   mul_add;
    assign mul_sum = {1'b0, acc[WIDTH-1:0]} + {1'b0, mcand};
    assign mul_add = mplr[0] ? mul_sum : {1'b0, acc[WIDTH-1:0]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // try to subtract the divisor. A non-negative result is kept, and the
    // quotient bit is set to 1.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ok;
    assign div_shift = {acc[WIDTH-1:0], mplr[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mcand};
    assign div_ok    = !div_trial[WIDTH];

    // ---------------------------------------------------------------------
    // Sign fixup
    // ---------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_res;
    logic [WIDTH-1:0]   lo_res;

    assign prod     = {acc[WIDTH-1:0], mplr};
    assign prod_fix = sq ? ('0 - prod) : prod;
    assign quo_fix  = sq ? ('0 - mplr) : mplr;
    assign rem_fix  = sr ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];

    always_comb begin
        hi_res = prod_fix[2*WIDTH-1:WIDTH];
        lo_res = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (mcand == '0) begin
                // Divide by zero: all-ones quotient and the untouched dividend.
                hi_res = a_orig;
                lo_res = '1;
            end else begin
                hi_res = rem_fix;
                lo_res = quo_fix;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Control and state
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            count  <= '0;
            is_div <= 1'b0;
            sq     <= 1'b0;
            sr     <= 1'b0;
            acc    <= '0;
            mplr   <= '0;
            mcand  <= '0;
            a_orig <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op <= OP_DIVU) begin
                            state  <= S_RUN;
                            count  <= '0;
                            is_div <= op_is_div;
                            sq     <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            sr     <= op_signed && a[WIDTH-1];
                            acc    <= '0;
                            mplr   <= a_mag;
                            mcand  <= b_mag;
                            a_orig <= a;
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end

                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (is_div) begin
                            acc  <= div_ok ? div_trial : div_shift;
                            mplr <= {mplr[WIDTH-2:0], div_ok};
                        end else begin
                            acc  <= {1'b0, mul_add[WIDTH:1]};
                            mplr <= {mul_add[0], mplr[WIDTH-1:1]};
                        end
                        count <= count + 1'b1;
                        if (count == CW'(ITER - 1))
                            state <= S_FIXUP;
                    end
                end

                S_FIXUP: begin
                    state <= S_IDLE;
                    if (!flush) begin
                        hi   <= hi_res;
                        lo   <= lo_res;
                        done <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign stall = busy && (start || rd_req);

endmodule
